fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequences instruction fetch: owns the PC, issues requests to the instruction memory over a
//  valid/ready handshake, buffers returned words in a small skid FIFO, and presents them to decode.
//  Applies EX-stage redirects (target = PC_EX + PC_DISP) and discards in-flight and buffered
//  wrong-path words. Sits between the instruction memory port and the fetch/decode pipeline register.
// PARAMETERS
//  XLEN       32  address/instruction width (equals `INST_SIZE)
//  RESET_PC   0   first fetch address after reset
//  BUF_DEPTH  2   instruction buffer entries (power of two, >=2)
// PORTS
//  clk            in   1     clock, all state updates on posedge
//  rst            in   1     reset, asynchronous, active-low
//  imem_req_valid out  1     fetch request valid
//  imem_req_ready in   1     memory accepts request this cycle
//  imem_req_addr  out  XLEN  fetch address (word aligned)
//  imem_rsp_valid in   1     response word valid (in order, >=1 cycle after accept)
//  imem_rsp_data  in   XLEN  response instruction word
//  redir_valid    in   1     EX redirect (taken branch/jump)
//  pc_ex          in   XLEN  PC of redirecting instruction
//  pc_disp        in   XLEN  displacement added to pc_ex
//  dec_ready      in   1     decode consumes instr this cycle
//  instr_valid    out  1     instr/instr_pc valid to decode
//  instr          out  XLEN  instruction word
//  instr_pc       out  XLEN  PC of instr
// BEHAVIOUR
//  - Reset (rst=0): pc=RESET_PC, state=IDLE, buffer empty, kill=0; imem_req_valid=0,
//    instr_valid=0, instr=0, instr_pc=0 (outputs forced to 0 combinationally while in reset).
//  - Max one outstanding request. States: IDLE->REQ (1 cycle after reset release).
//    REQ: imem_req_valid=1 iff (count + 0) < BUF_DEPTH; on valid&ready: latch pc as inflight_pc,
//    pc<=pc+`INCR_SIZE, ->WAIT. WAIT: on imem_rsp_valid push {data,inflight_pc} unless kill; ->REQ
//    (request may issue same cycle only from REQ, i.e. earliest next cycle). Req->rsp min 2 cycles.
//  - Space check counts the outstanding slot: request only if count + outstanding < BUF_DEPTH.
//  - Buffer: FIFO, push on accepted response, pop on instr_valid&dec_ready; push+pop same cycle
//    when full is legal (count unchanged). instr_valid = !empty; instr/instr_pc = head entry.
//  - Redirect (redir_valid=1, highest priority): pc <= (pc_ex + pc_disp) mod 2^XLEN with [1:0]
//    forced to 0; buffer flushed; pop that cycle suppressed (instr_valid still shown, ignored).
//    If in WAIT with response not arriving this cycle: set kill, state stays WAIT; the next
//    response is dropped, kill cleared, ->REQ. Response arriving same cycle as redirect: dropped.
//    In REQ: request in same cycle is suppressed (imem_req_valid=0); new target issued next cycle.
//  - Back-to-back redirects: last one wins; kill remains single bit (only one outstanding).
//  - PC wraps modulo 2^XLEN at 0xFFFF_FFFC -> 0x0000_0000, no error.
//  - Async reset mid-transaction: all state cleared; a late response after reset release with no
//    outstanding request is ignored (push gated by state==WAIT).
// CONFIGURATION
//  FETCH_CTRL_PERF_EN defined: adds outputs perf_stall_cnt (32b, cycles with REQ state and
//  imem_req_valid&!imem_req_ready or buffer full) and perf_redir_cnt (32b, redirects accepted);
//  both reset to 0, saturate at all-ones. Undefined: ports and counters absent, behaviour identical.
// STRUCTURE
//  - Constants.v: state encodings `FC_IDLE/`FC_REQ/`FC_WAIT, reuse `INST_SIZE, `INCR_SIZE,
//    `INST_SIZE_ZEROS.
//  - Sub-module fetch_buf: BUF_DEPTH x (2*XLEN) FIFO with push/pop/flush, count, full/empty.
//  - fetch_ctrl: FSM, PC register, kill bit, redirect adder, perf counters.
// TESTING
//  1 Reset release, mem ready always, rsp 1 cycle after accept, dec_ready=1 -> addrs 0,4,8,...;
//    instr_pc follows, first instr_valid no earlier than 3 cycles after reset release.
//  2 dec_ready=0 for 10 cycles -> exactly BUF_DEPTH words buffered, no further req; release ->
//    words drain in order, no loss/duplicate.
//  3 redir_valid with pc_ex=0x100, pc_disp=0x20 while in WAIT -> pending rsp dropped, buffer
//    empty, next imem_req_addr=0x120, next instr_pc=0x120.
//  4 Redirect same cycle as imem_rsp_valid and as a full-buffer pop -> word dropped, count=0.
//  5 RESET_PC=0xFFFF_FFF8 -> addrs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; pc_disp=0xFFFF_FFF2 from
//    pc_ex=0x10 -> target 0x0000_0000 (bits[1:0] cleared).
//  6 rst asserted while WAIT, response arrives during reset and 1 cycle after -> both ignored,
//    fetch restarts at RESET_PC; with FETCH_CTRL_PERF_EN counters read 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the fetch controller: word size, PC increment and FSM encodings.
package fetch_ctrl_pkg;

   localparam int unsigned INST_SIZE = 32;
   localparam int unsigned INCR_SIZE = 4;
   localparam logic [INST_SIZE-1:0] INST_SIZE_ZEROS = '0;

   localparam logic [1:0] FC_IDLE = 2'd0;
   localparam logic [1:0] FC_REQ  = 2'd1;
   localparam logic [1:0] FC_WAIT = 2'd2;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response port between fetch_ctrl (master) and the memory (slave).
interface fetch_ctrl_if
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = INST_SIZE
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );
endinterface

// File: rtl/fetch_ctrl_buf.sv
// fetch_buf: small FIFO of {instr, pc} entries with synchronous flush, count and full/empty.
module fetch_buf
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 2 * INST_SIZE
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      cnt;
   logic             do_pop;

   assign do_pop = pop && !empty;
   assign empty  = (cnt == '0);
   assign full   = (cnt == (PW+1)'(DEPTH));
   assign count  = cnt;
   assign rdata  = mem[rd_ptr];

   // Push while full is accepted only alongside a pop; the caller guarantees that.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         cnt <= cnt + (PW+1)'(push) - (PW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencing, single-outstanding imem requests, redirect/kill handling.
// Optional FETCH_CTRL_PERF_EN adds saturating stall and redirect counters.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned        XLEN      = INST_SIZE,
   parameter logic [XLEN-1:0]    RESET_PC  = '0,
   parameter int unsigned        BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   fetch_ctrl_if.master    imem,
   input  logic            redir_valid,
   input  logic [XLEN-1:0] pc_ex,
   input  logic [XLEN-1:0] pc_disp,
   input  logic            dec_ready,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc
`ifdef FETCH_CTRL_PERF_EN
  ,output logic [31:0]     perf_stall_cnt,
   output logic [31:0]     perf_redir_cnt
`endif
);
   localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

   logic [1:0]        state;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   inflight_pc;
   logic              kill;

   logic [XLEN-1:0]   redir_sum;
   logic [XLEN-1:0]   redir_tgt;
   logic              outstanding;
   logic              space_ok;
   logic              req_valid;
   logic              req_fire;
   logic              rsp_take;
   logic              push;
   logic              pop;

   logic [CW-1:0]     buf_count;
   logic              buf_full;
   logic              buf_empty;
   logic [2*XLEN-1:0] buf_rdata;

   assign redir_sum   = pc_ex + pc_disp;
   assign redir_tgt   = {redir_sum[XLEN-1:2], 2'b00};

   // The in-flight word already owns a buffer slot, so it counts against free space.
   assign outstanding = (state == FC_WAIT);
   assign space_ok    = (buf_count + CW'(outstanding)) < CW'(BUF_DEPTH);

   assign req_valid   = rst && (state == FC_REQ) && space_ok && !redir_valid;
   assign req_fire    = req_valid && imem.imem_req_ready;
   assign rsp_take    = (state == FC_WAIT) && imem.imem_rsp_valid;
   assign push        = rsp_take && !kill && !redir_valid && (!buf_full || pop);
   assign pop         = instr_valid && dec_ready && !redir_valid;

   assign imem.imem_req_valid = req_valid;
   assign imem.imem_req_addr  = rst ? pc : '0;

   assign instr_valid = rst && !buf_empty;
   assign instr       = rst ? buf_rdata[2*XLEN-1:XLEN] : '0;
   assign instr_pc    = rst ? buf_rdata[XLEN-1:0]      : '0;

   fetch_buf #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (2 * XLEN)
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redir_valid),
      .wdata ({imem.imem_rsp_data, inflight_pc}),
      .rdata (buf_rdata),
      .count (buf_count),
      .full  (buf_full),
      .empty (buf_empty)
   );

   // A redirect in WAIT without a response arms kill so the stale word is dropped on arrival.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= FC_IDLE;
         pc          <= RESET_PC;
         inflight_pc <= '0;
         kill        <= 1'b0;
      end else begin
         case (state)
            FC_IDLE: begin
               state <= FC_REQ;
            end
            FC_REQ: begin
               if (req_fire) begin
                  inflight_pc <= pc;
                  pc          <= pc + XLEN'(INCR_SIZE);
                  state       <= FC_WAIT;
               end
            end
            FC_WAIT: begin
               if (rsp_take) begin
                  kill  <= 1'b0;
                  state <= FC_REQ;
               end else if (redir_valid) begin
                  kill  <= 1'b1;
               end
            end
            default: begin
               state <= FC_IDLE;
            end
         endcase
         if (redir_valid) begin
            pc <= redir_tgt;
         end
      end
   end

`ifdef FETCH_CTRL_PERF_EN
   logic stall_ev;

   assign stall_ev = (state == FC_REQ) &&
                     ((req_valid && !imem.imem_req_ready) || buf_full);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cnt <= '0;
         perf_redir_cnt <= '0;
      end else begin
         if (stall_ev && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (redir_valid && (perf_redir_cnt != '1)) begin
            perf_redir_cnt <= perf_redir_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed sequences, a redirect vector table and randomized traffic
// checked against a stream-level model (expected PC sequence and memory contents).
module tb_fetch_ctrl;
   localparam int unsigned BUF_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        redir_valid;
   logic [31:0] pc_ex, pc_disp;
   logic        dec_ready;
   logic        instr_valid;
   logic [31:0] instr, instr_pc;
   logic        w_iv;
   logic [31:0] w_instr, w_ipc;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] perf_stall_cnt, perf_redir_cnt, w_ps, w_pr;
`endif

   always #5 clk = ~clk;

   fetch_ctrl_if #(.XLEN(32)) imem ();
   fetch_ctrl_if #(.XLEN(32)) wimem ();

   fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(BUF_DEPTH)) dut (
      .clk(clk), .rst(rst), .imem(imem),
      .redir_valid(redir_valid), .pc_ex(pc_ex), .pc_disp(pc_disp), .dec_ready(dec_ready),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_CTRL_PERF_EN
     ,.perf_stall_cnt(perf_stall_cnt), .perf_redir_cnt(perf_redir_cnt)
`endif
   );

   fetch_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(BUF_DEPTH)) dut_w (
      .clk(clk), .rst(rst), .imem(wimem),
      .redir_valid(1'b0), .pc_ex(32'h0), .pc_disp(32'h0), .dec_ready(1'b1),
      .instr_valid(w_iv), .instr(w_instr), .instr_pc(w_ipc)
`ifdef FETCH_CTRL_PERF_EN
     ,.perf_stall_cnt(w_ps), .perf_redir_cnt(w_pr)
`endif
   );

   int vec = 0;
   int mis = 0;

   // memory model and expected-stream state
   bit          pend, w_pend, mem_manual, acc_seen, cons_seen;
   int          cd, dly_lo, dly_hi, ready_mode;
   logic [31:0] pend_addr, w_addr, exp_pc, exp_req, last_acc, last_cons;
   int          n_acc, n_cons, n_redir, rel_cyc, first_valid;
   logic [31:0] w_addrs [$];

   typedef struct {
      int          mode;
      logic [31:0] pc_ex;
      logic [31:0] pc_disp;
      logic [31:0] exp_tgt;
   } rvec_t;
   rvec_t tbl [6];

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      acc_seen  = 1'b0;
      cons_seen = 1'b0;
      if (!rst) begin
         chk("rst_req_valid", 32'(imem.imem_req_valid), 32'd0);
         chk("rst_instr_valid", 32'(instr_valid), 32'd0);
         chk("rst_instr", instr, 32'd0);
         chk("rst_instr_pc", instr_pc, 32'd0);
         pend = 1'b0; w_pend = 1'b0; cd = 0; n_redir = 0;
         exp_pc = 32'h0; exp_req = 32'h0;
      end else begin
         if (instr_valid && first_valid < 0) first_valid = rel_cyc;
         if (imem.imem_rsp_valid && pend) pend = 1'b0;
         if (instr_valid && dec_ready && !redir_valid) begin
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr", instr, memfn(exp_pc));
            last_cons = instr_pc; exp_pc += 32'd4; n_cons++; cons_seen = 1'b1;
         end
         if (imem.imem_req_valid && imem.imem_req_ready) begin
            chk("one_outstanding", 32'(pend), 32'd0);
            chk("req_addr", imem.imem_req_addr, exp_req);
            last_acc = imem.imem_req_addr; exp_req += 32'd4; n_acc++; acc_seen = 1'b1;
            pend = 1'b1; pend_addr = imem.imem_req_addr;
            cd = dly_lo + int'($urandom_range(0, dly_hi - dly_lo));
         end
         if (redir_valid) begin
            chk("req_during_redir", 32'(imem.imem_req_valid), 32'd0);
            exp_pc  = (pc_ex + pc_disp) & 32'hFFFF_FFFC;
            exp_req = exp_pc;
            n_redir++;
         end
         if (wimem.imem_req_valid) begin
            w_addrs.push_back(wimem.imem_req_addr);
            w_pend = 1'b1; w_addr = wimem.imem_req_addr;
         end
         rel_cyc++;
      end
      @(posedge clk);
      #1;
      if (!mem_manual) begin
         imem.imem_rsp_valid = 1'b0;
         if (pend && cd > 0) begin
            cd--;
            if (cd == 0) begin
               imem.imem_rsp_valid = 1'b1;
               imem.imem_rsp_data  = memfn(pend_addr);
            end
         end
         imem.imem_req_ready = (ready_mode == 0) ? 1'b1 :
                               (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
      end
      wimem.imem_rsp_valid = w_pend;
      wimem.imem_rsp_data  = memfn(w_addr);
      wimem.imem_req_ready = 1'b1;
      w_pend = 1'b0;
   endtask

   task automatic wait_for(input bit want_cons, output bit got);
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         tick();
         got = want_cons ? cons_seen : acc_seen;
      end
   endtask

   task automatic expect_acc(input string nm, input logic [31:0] exp);
      bit g;
      wait_for(1'b0, g);
      chk(nm, g ? last_acc : ~exp, exp);
   endtask

   task automatic expect_cons(input string nm, input logic [31:0] exp);
      bit g;
      wait_for(1'b1, g);
      chk(nm, g ? last_cons : ~exp, exp);
   endtask

   initial begin
      bit got;
      int base;
      tbl[0] = '{mode: 0, pc_ex: 32'h0000_0100, pc_disp: 32'h0000_0020, exp_tgt: 32'h0000_0120};
      tbl[1] = '{mode: 1, pc_ex: 32'h0000_0200, pc_disp: 32'h0000_0040, exp_tgt: 32'h0000_0240};
      tbl[2] = '{mode: 2, pc_ex: 32'h0000_0010, pc_disp: 32'hFFFF_FFF2, exp_tgt: 32'h0000_0000};
      tbl[3] = '{mode: 0, pc_ex: 32'hFFFF_FFF0, pc_disp: 32'h0000_0008, exp_tgt: 32'hFFFF_FFF8};
      tbl[4] = '{mode: 1, pc_ex: 32'h0000_0003, pc_disp: 32'h0000_0002, exp_tgt: 32'h0000_0004};
      tbl[5] = '{mode: 2, pc_ex: 32'hFFFF_FFFC, pc_disp: 32'h0000_0008, exp_tgt: 32'h0000_0004};

      rst = 1'b0; redir_valid = 1'b0; pc_ex = '0; pc_disp = '0; dec_ready = 1'b1;
      imem.imem_req_ready = 1'b1; imem.imem_rsp_valid = 1'b0; imem.imem_rsp_data = '0;
      wimem.imem_req_ready = 1'b1; wimem.imem_rsp_valid = 1'b0; wimem.imem_rsp_data = '0;
      mem_manual = 1'b0; ready_mode = 0; dly_lo = 1; dly_hi = 1;

      // reset, then sequential fetch from RESET_PC
      repeat (3) tick();
      rst = 1'b1; rel_cyc = 0; first_valid = -1; w_addrs.delete();
      expect_acc("t1_addr0", 32'h0);
      expect_acc("t1_addr4", 32'h4);
      expect_acc("t1_addr8", 32'h8);
      repeat (12) tick();
      chk("t1_first_valid_latency", 32'(first_valid >= 3), 32'd1);
      chk("wrap_nreq", 32'(w_addrs.size() >= 3), 32'd1);
      chk("wrap_addr0", w_addrs[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", w_addrs[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", w_addrs[2], 32'h0000_0000);

      // decode stall: buffer fills exactly, then drains in order
      dec_ready = 1'b0;
      repeat (10) tick();
      chk("t2_buffered", 32'(n_acc - n_cons), 32'(BUF_DEPTH));
      chk("t2_no_req", 32'(imem.imem_req_valid), 32'd0);
      chk("t2_no_pending", 32'(pend), 32'd0);
      dec_ready = 1'b1; base = n_cons;
      repeat (10) tick();
      chk("t2_drained", 32'(n_cons - base >= 3), 32'd1);

      // redirect table
      for (int k = 0; k < 6; k++) begin
         dec_ready = 1'b1;
         if (tbl[k].mode == 0) begin
            dly_lo = 3; dly_hi = 3;
            wait_for(1'b0, got);
         end else if (tbl[k].mode == 1) begin
            dly_lo = 1; dly_hi = 1; dec_ready = 1'b0; got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
               tick();
               got = imem.imem_rsp_valid && instr_valid;
            end
            dec_ready = 1'b1;
         end else begin
            ready_mode = 2;
            repeat (6) tick();
            got = imem.imem_req_valid;
         end
         chk($sformatf("v%0d_setup", k), 32'(got), 32'd1);
         redir_valid = 1'b1; pc_ex = tbl[k].pc_ex; pc_disp = tbl[k].pc_disp;
         tick();
         redir_valid = 1'b0; ready_mode = 0; dly_lo = 1; dly_hi = 1;
         chk($sformatf("v%0d_flushed", k), 32'(instr_valid), 32'd0);
         expect_acc($sformatf("v%0d_tgt_addr", k), tbl[k].exp_tgt);
         expect_cons($sformatf("v%0d_tgt_pc", k), tbl[k].exp_tgt);
         repeat (4) tick();
      end

      // reset while WAIT; responses during and just after reset are ignored
      dly_lo = 3; dly_hi = 3;
      wait_for(1'b0, got);
      chk("t6_setup", 32'(got), 32'd1);
      rst = 1'b0; mem_manual = 1'b1;
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'hDEAD_BEEF;
      tick();
      rst = 1'b1; rel_cyc = 0; first_valid = -1; mem_manual = 1'b0; dly_lo = 1; dly_hi = 1;
`ifdef FETCH_CTRL_PERF_EN
      chk("t6_perf_stall", perf_stall_cnt, 32'd0);
      chk("t6_perf_redir", perf_redir_cnt, 32'd0);
`endif
      tick();
      expect_acc("t6_restart_addr", 32'h0);
      expect_cons("t6_restart_pc", 32'h0);

      // randomized traffic against the stream model
      ready_mode = 1; dly_lo = 1; dly_hi = 3;
      for (int i = 0; i < 800; i++) begin
         dec_ready   = ($urandom_range(0, 3) != 0);
         redir_valid = ($urandom_range(0, 24) == 0);
         pc_ex       = $urandom;
         pc_disp     = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 255));
         tick();
      end
      redir_valid = 1'b0;
      tick();
`ifdef FETCH_CTRL_PERF_EN
      chk("perf_redir_total", perf_redir_cnt, 32'(n_redir));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end
endmodule
